// File: rtl/cms_pkg.sv
// -----------------------------------------------------------------------------
// cms_pkg
// Shared constants for the continuous monitoring system (CMS) trace path.
// Provides the default trace payload geometry (instr, clock delta, pc), the
// performance event counter geometry and a helper that sizes a trace packet.
// -----------------------------------------------------------------------------
package cms_pkg;

  localparam int XLEN                                = 64;
  localparam int RISC_V_INSTRUCTION_WIDTH            = 32;
  localparam int NO_OF_PERFORMANCE_EVENTS            = 115;
  localparam int PERFORMANCE_EVENT_MOD_COUNTER_WIDTH = 7;

  // Payload = {instr, clock delta, pc}.
  localparam int TRACE_PAYLOAD_WIDTH = 2 * RISC_V_INSTRUCTION_WIDTH + XLEN;

  localparam logic [RISC_V_INSTRUCTION_WIDTH-1:0] WFI_INSTRUCTION = 32'h1050_0073;

  // Width of one streamed packet: payload followed by every event counter.
  function automatic int packet_width(input int payload_w, input int n_events,
                                      input int counter_w);
    return payload_w + n_events * counter_w;
  endfunction

  localparam int AXI_DATA_WIDTH = packet_width(TRACE_PAYLOAD_WIDTH,
                                               NO_OF_PERFORMANCE_EVENTS,
                                               PERFORMANCE_EVENT_MOD_COUNTER_WIDTH);

endpackage

// File: rtl/cms_sync_fifo.sv
// -----------------------------------------------------------------------------
// cms_sync_fifo
// Single-clock first-word-fall-through FIFO. The head entry is always visible
// on pop_data; it is only meaningful while empty=0.
//
// Ports:
//   clk        in   clock, all logic on posedge
//   rst        in   synchronous active-high reset (empties the FIFO)
//   push       in   write push_data (ignored when full unless pop is accepted)
//   push_data  in   WIDTH  entry to write
//   pop        in   remove the head entry (ignored when empty)
//   pop_data   out  WIDTH  head entry
//   full       out  DEPTH entries held
//   empty      out  no entries held
// -----------------------------------------------------------------------------
module cms_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16   // power of two, >= 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A full FIFO can still take a write when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  assign pop_data = mem[rd_ptr[AW-1:0]];

  // NOTE: non-blocking (<=) for all clocked state so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, and a reset-free array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/cms_trace_axis_streamer.sv
// -----------------------------------------------------------------------------
// cms_trace_axis_streamer
// Captures one trace packet per write_enable cycle and streams it over an
// AXI4-Stream master towards the DMA. A packet is the caller payload followed
// by saturating per-event counters that count events since the last capture.
// Also qualifies the GPIO control write strobe (rising edge or level).
//
// Ports:
//   clk                 in   clock
//   rst                 in   synchronous active-high reset
//   write_enable        in   capture a packet this cycle
//   payload_in          in   PAYLOAD_WIDTH  upper packet field
//   tlast_req           in   force tlast on this cycle's packet (e.g. WFI)
//   tlast_interval      in   32  packets per tlast group, 0 = no interval tlast
//   performance_events  in   NO_OF_EVENTS  event bitmap for this cycle
//   ctrl_we             in   raw control write strobe
//   ctrl_we_pulse       out  qualified control write strobe
//   counters_flat       out  live counters, counter 0 in the MSBs
//   M_AXIS_tvalid/tready/tdata/tlast  AXI4-Stream master
//   dropped_count       out  32  packets lost to a full FIFO (saturating)
// -----------------------------------------------------------------------------
module cms_trace_axis_streamer
  import cms_pkg::*;
#(
  parameter int PAYLOAD_WIDTH   = TRACE_PAYLOAD_WIDTH,
  parameter int NO_OF_EVENTS    = NO_OF_PERFORMANCE_EVENTS,
  parameter int COUNTER_WIDTH   = PERFORMANCE_EVENT_MOD_COUNTER_WIDTH,
  parameter int FIFO_DEPTH      = 16,
  parameter bit CTRL_WE_POSEDGE = 1'b1,
  localparam int CNT_FLAT_W     = NO_OF_EVENTS * COUNTER_WIDTH,
  localparam int PKT_W          = packet_width(PAYLOAD_WIDTH, NO_OF_EVENTS, COUNTER_WIDTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     write_enable,
  input  logic [PAYLOAD_WIDTH-1:0] payload_in,
  input  logic                     tlast_req,
  input  logic [31:0]              tlast_interval,
  input  logic [NO_OF_EVENTS-1:0]  performance_events,
  input  logic                     ctrl_we,
  output logic                     ctrl_we_pulse,
  output logic [CNT_FLAT_W-1:0]    counters_flat,
  output logic                     M_AXIS_tvalid,
  input  logic                     M_AXIS_tready,
  output logic [PKT_W-1:0]         M_AXIS_tdata,
  output logic                     M_AXIS_tlast,
  output logic [31:0]              dropped_count
);

  // ---------------------------------------------------------------------------
  // Control strobe qualification
  // ---------------------------------------------------------------------------
  logic we_d;

  always_ff @(posedge clk) begin
    if (rst) we_d <= 1'b0;
    else     we_d <= ctrl_we;
  end

  if (CTRL_WE_POSEDGE) begin : g_we_edge
    assign ctrl_we_pulse = ctrl_we & ~we_d;
  end else begin : g_we_level
    assign ctrl_we_pulse = ctrl_we;
  end

  // ---------------------------------------------------------------------------
  // Event counters: saturate, cleared by a capture (clear beats increment)
  // ---------------------------------------------------------------------------
  logic [COUNTER_WIDTH-1:0] counters [NO_OF_EVENTS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NO_OF_EVENTS; i++) begin
      if (rst || write_enable)
        counters[i] <= '0;
      else if (performance_events[i] && (counters[i] != '1))
        counters[i] <= counters[i] + COUNTER_WIDTH'(1);
    end
  end

  // NOTE: every always_comb output gets a default first, so no path through
  // the block can leave it unassigned and infer a latch.
  always_comb begin
    counters_flat = '0;
    for (int i = 0; i < NO_OF_EVENTS; i++)
      counters_flat[(NO_OF_EVENTS-1-i)*COUNTER_WIDTH +: COUNTER_WIDTH] = counters[i];
  end

  // ---------------------------------------------------------------------------
  // Push / drop / tlast grouping
  // ---------------------------------------------------------------------------
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  logic [PKT_W:0]   fifo_head;   // {tlast, packet}
  logic [31:0]      group_count;
  logic             interval_hit;
  logic             push_tlast;

  assign fifo_pop  = M_AXIS_tvalid & M_AXIS_tready;
  assign fifo_push = write_enable & (~fifo_full | fifo_pop);

  // 33-bit compare so group_count+1 cannot wrap past the interval.
  assign interval_hit = (tlast_interval != '0) &&
                        (({1'b0, group_count} + 33'd1) >= {1'b0, tlast_interval});
  assign push_tlast   = tlast_req | interval_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      group_count   <= '0;
      dropped_count <= '0;
    end else if (write_enable) begin
      if (fifo_push)
        group_count <= push_tlast ? '0 : group_count + 32'd1;
      else if (dropped_count != '1)
        dropped_count <= dropped_count + 32'd1;
    end
  end

  cms_sync_fifo #(
    .WIDTH (PKT_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({push_tlast, payload_in, counters_flat}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // ---------------------------------------------------------------------------
  // AXI4-Stream output: data/last forced to zero while nothing is offered
  // ---------------------------------------------------------------------------
  assign M_AXIS_tvalid = ~fifo_empty;
  assign M_AXIS_tdata  = M_AXIS_tvalid ? fifo_head[PKT_W-1:0] : '0;
  assign M_AXIS_tlast  = M_AXIS_tvalid & fifo_head[PKT_W];

endmodule

// File: tb/tb_cms_trace_axis_streamer.sv
// -----------------------------------------------------------------------------
// tb_cms_trace_axis_streamer
// Directed bench for cms_trace_axis_streamer with default geometry. A second
// instance with CTRL_WE_POSEDGE=0 shares the inputs to check the level mode.
// Inputs change 1 ns after the rising edge; outputs are sampled before the
// next rising edge.
// -----------------------------------------------------------------------------
module tb_cms_trace_axis_streamer;

  localparam int PW  = 128;
  localparam int N   = 115;
  localparam int CW  = 7;
  localparam int CFW = N * CW;
  localparam int W   = PW + CFW;

  logic           clk = 1'b0;
  logic           rst;
  logic           write_enable;
  logic [PW-1:0]  payload_in;
  logic           tlast_req;
  logic [31:0]    tlast_interval;
  logic [N-1:0]   performance_events;
  logic           ctrl_we;
  logic           m_tready;

  logic           ctrl_we_pulse;
  logic [CFW-1:0] counters_flat;
  logic           m_tvalid;
  logic [W-1:0]   m_tdata;
  logic           m_tlast;
  logic [31:0]    dropped_count;

  logic           l_ctrl_we_pulse;
  logic [CFW-1:0] l_counters_flat;
  logic           l_tvalid;
  logic [W-1:0]   l_tdata;
  logic           l_tlast;
  logic [31:0]    l_dropped_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cms_trace_axis_streamer dut (
    .clk                (clk),
    .rst                (rst),
    .write_enable       (write_enable),
    .payload_in         (payload_in),
    .tlast_req          (tlast_req),
    .tlast_interval     (tlast_interval),
    .performance_events (performance_events),
    .ctrl_we            (ctrl_we),
    .ctrl_we_pulse      (ctrl_we_pulse),
    .counters_flat      (counters_flat),
    .M_AXIS_tvalid      (m_tvalid),
    .M_AXIS_tready      (m_tready),
    .M_AXIS_tdata       (m_tdata),
    .M_AXIS_tlast       (m_tlast),
    .dropped_count      (dropped_count)
  );

  cms_trace_axis_streamer #(.CTRL_WE_POSEDGE(1'b0)) dut_level (
    .clk                (clk),
    .rst                (rst),
    .write_enable       (write_enable),
    .payload_in         (payload_in),
    .tlast_req          (tlast_req),
    .tlast_interval     (tlast_interval),
    .performance_events (performance_events),
    .ctrl_we            (ctrl_we),
    .ctrl_we_pulse      (l_ctrl_we_pulse),
    .counters_flat      (l_counters_flat),
    .M_AXIS_tvalid      (l_tvalid),
    .M_AXIS_tready      (m_tready),
    .M_AXIS_tdata       (l_tdata),
    .M_AXIS_tlast       (l_tlast),
    .dropped_count      (l_dropped_count)
  );

  task automatic check(input string tag, input logic [1023:0] obs,
                       input logic [1023:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  // Expected packet with one non-zero counter field (idx < 0 means none).
  function automatic logic [W-1:0] make_pkt(input logic [PW-1:0] pl, input int idx,
                                            input int val);
    logic [W-1:0] p;
    p = '0;
    p[W-1 -: PW] = pl;
    if (idx >= 0) p[(N-1-idx)*CW +: CW] = CW'(val);
    return p;
  endfunction

  function automatic logic [PW-1:0] payload_of(input logic [W-1:0] d);
    return d[W-1 -: PW];
  endfunction

  function automatic logic [CW-1:0] field_of(input logic [CFW-1:0] c, input int idx);
    return c[(N-1-idx)*CW +: CW];
  endfunction

  initial begin
    rst                = 1'b1;
    write_enable       = 1'b0;
    payload_in         = '0;
    tlast_req          = 1'b0;
    tlast_interval     = '0;
    performance_events = '0;
    ctrl_we            = 1'b0;
    m_tready           = 1'b0;

    // ---- Reset state --------------------------------------------------------
    do_reset();
    check("rst_tvalid",   m_tvalid, 1'b0);
    check("rst_tdata",    m_tdata, '0);
    check("rst_tlast",    m_tlast, 1'b0);
    check("rst_dropped",  dropped_count, 32'd0);
    check("rst_counters", counters_flat, '0);
    check("rst_pulse",    ctrl_we_pulse, 1'b0);

    // ---- Control strobe: edge mode pulses once, level mode follows ---------
    ctrl_we = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("we_edge_%0d", k), ctrl_we_pulse, (k == 0));
      check($sformatf("we_level_%0d", k), l_ctrl_we_pulse, 1'b1);
      tick();
    end
    ctrl_we = 1'b0;
    #1;
    check("we_edge_low", ctrl_we_pulse, 1'b0);

    // ---- Event bit 3 for 4 cycles, capture on the 5th (its event dropped) ---
    m_tready = 1'b1;
    performance_events[3] = 1'b1;
    repeat (4) tick();
    check("cnt3_live", field_of(counters_flat, 3), 7'd4);
    write_enable = 1'b1;
    payload_in   = 128'hA5A5_0000_1111_2222_3333_4444_5555_6666;
    tick();
    write_enable = 1'b0;
    performance_events = '0;
    #1;
    check("cap3_tvalid", m_tvalid, 1'b1);
    check("cap3_tdata",  m_tdata, make_pkt(128'hA5A5_0000_1111_2222_3333_4444_5555_6666, 3, 4));
    check("cap3_clear",  counters_flat, '0);
    tick();
    check("cap3_drained", m_tvalid, 1'b0);
    check("cap3_tdata0",  m_tdata, '0);

    // ---- Saturation: event 0 for 200 cycles ---------------------------------
    performance_events[0] = 1'b1;
    repeat (200) tick();
    performance_events = '0;
    #1;
    check("sat_live", field_of(counters_flat, 0), 7'd127);
    write_enable = 1'b1;
    payload_in   = 128'h77;
    tick();
    write_enable = 1'b0;
    #1;
    check("sat_tdata", m_tdata, make_pkt(128'h77, 0, 127));
    tick();

    // ---- tlast interval 3: packets 3 and 6 ----------------------------------
    do_reset();
    tlast_interval = 32'd3;
    m_tready       = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      write_enable = 1'b1;
      payload_in   = PW'(k);
      tick();
      check($sformatf("int_payload_%0d", k), payload_of(m_tdata), PW'(k));
      check($sformatf("int_tlast_%0d", k), m_tlast, (k == 3 || k == 6));
    end
    write_enable = 1'b0;
    tick();
    check("int_drained", m_tvalid, 1'b0);

    // ---- tlast_req on packet 2 restarts the group: packets 2 and 5 ----------
    do_reset();
    for (int k = 1; k <= 7; k++) begin
      write_enable = 1'b1;
      tlast_req    = (k == 2);
      payload_in   = PW'(k);
      tick();
      check($sformatf("req_tlast_%0d", k), m_tlast, (k == 2 || k == 5));
    end
    write_enable = 1'b0;
    tlast_req    = 1'b0;
    tick();

    // ---- Back-pressure: 20 writes into 16 entries ---------------------------
    do_reset();
    tlast_interval = '0;
    m_tready       = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      write_enable = 1'b1;
      payload_in   = PW'(100 + k);
      tick();
    end
    write_enable = 1'b0;
    #1;
    check("bp_tvalid",  m_tvalid, 1'b1);
    check("bp_dropped", dropped_count, 32'd4);
    tick();
    check("bp_stable", m_tdata, make_pkt(PW'(101), -1, 0));
    m_tready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      #1;
      check($sformatf("bp_valid_%0d", k), m_tvalid, 1'b1);
      check($sformatf("bp_order_%0d", k), payload_of(m_tdata), PW'(101 + k));
      tick();
    end
    check("bp_empty", m_tvalid, 1'b0);

    // ---- Full FIFO with simultaneous push and pop ---------------------------
    m_tready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      write_enable = 1'b1;
      payload_in   = PW'(200 + k);
      tick();
    end
    write_enable = 1'b1;
    m_tready     = 1'b1;
    payload_in   = PW'(300);
    tick();
    write_enable = 1'b0;
    m_tready     = 1'b0;
    #1;
    check("pp_dropped", dropped_count, 32'd4);
    check("pp_head",    payload_of(m_tdata), PW'(201));
    m_tready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      #1;
      check($sformatf("pp_order_%0d", k), payload_of(m_tdata),
            (k < 15) ? PW'(201 + k) : PW'(300));
      tick();
    end
    check("pp_empty", m_tvalid, 1'b0);

    // ---- Reset with 5 packets buffered --------------------------------------
    m_tready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      write_enable = 1'b1;
      payload_in   = PW'(400 + k);
      tick();
    end
    write_enable = 1'b0;
    #1;
    check("mr_tvalid_before", m_tvalid, 1'b1);
    rst = 1'b1;
    tick();
    check("mr_tvalid", m_tvalid, 1'b0);
    check("mr_tdata",  m_tdata, '0);
    rst      = 1'b0;
    m_tready = 1'b1;
    tick();
    check("mr_still_empty", m_tvalid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cms_trace_axis_streamer.md
Name: cms_trace_axis_streamer

Overview:
- Captures one trace packet per qualified cycle and streams it to the DMA/FIFO path over an AXI4-Stream master.
- Each packet is a caller-supplied payload plus per-event performance counters. The counters count events since the previous captured packet.
- Also provides a rising-edge detector for the GPIO-driven control write strobe.
- Sits between the trace-qualification logic of the continuous monitoring system and the AXI DMA.

Parameters:
- PAYLOAD_WIDTH, 128: width of payload_in (instr, clock delta, pc).
- NO_OF_EVENTS, 115: number of performance event inputs and counters.
- COUNTER_WIDTH, 7: width of each event counter (saturating).
- FIFO_DEPTH, 16: internal buffer depth in packets; power of two, ≥2.
- CTRL_WE_POSEDGE, 1: 1 = ctrl_we_pulse is the rising edge of ctrl_we; 0 = ctrl_we_pulse equals ctrl_we.

Ports:
- clk  in  1  single clock, all logic posedge.
- rst  in  1  synchronous, active-high reset.
- write_enable  in  1  capture a packet this cycle.
- payload_in  in  PAYLOAD_WIDTH  upper packet field.
- tlast_req  in  1  force tlast on the packet captured this cycle (e.g. WFI).
- tlast_interval  in  32  packets per tlast group; 0 disables interval tlast.
- performance_events  in  NO_OF_EVENTS  event bitmap for this cycle.
- ctrl_we  in  1  raw control write strobe.
- ctrl_we_pulse  out  1  qualified control write strobe.
- counters_flat  out  NO_OF_EVENTS*COUNTER_WIDTH  live counters; counter 0 in the MSBs.
- M_AXIS_tvalid  out  1  AXIS valid.
- M_AXIS_tready  in  1  AXIS ready.
- M_AXIS_tdata  out  PAYLOAD_WIDTH+NO_OF_EVENTS*COUNTER_WIDTH  packet.
- M_AXIS_tlast  out  1  end of group.
- dropped_count  out  32  packets lost because the FIFO was full (saturating).

Behaviour:
- Reset:
  - FIFO empty; M_AXIS_tvalid=0, M_AXIS_tdata=0, M_AXIS_tlast=0.
  - All counters 0; group count 0; dropped_count 0; edge-detect register 0; ctrl_we_pulse=0.
- Edge detector:
  - ctrl_we is registered as we_d.
  - With CTRL_WE_POSEDGE=1, ctrl_we_pulse = ctrl_we & ~we_d (combinational). This gives one pulse per rising edge, in the same cycle ctrl_we first reads 1.
  - With CTRL_WE_POSEDGE=0, ctrl_we_pulse = ctrl_we.
- Counters:
  - Each cycle, counter[i] increments by 1 if performance_events[i]=1.
  - Counters saturate at 2^COUNTER_WIDTH-1; they never wrap.
  - In a write_enable cycle, every counter is cleared to 0. The clear has priority, so events in that cycle are discarded.
- Packet formation:
  - Packet = {payload_in, counter[0], …, counter[N-1]}, sampled in the write_enable cycle.
  - It uses the counter values before that cycle's clear.
- Push:
  - Occurs when write_enable=1 and (FIFO not full, or a pop happens in the same cycle).
  - Otherwise the packet is dropped, dropped_count increments (saturating), and the group count is unchanged.
- tlast per pushed packet: tlast = tlast_req | (tlast_interval≠0 & group_count+1 ≥ tlast_interval).
  - When a tlast=1 packet is pushed, group_count ← 0; otherwise group_count ← group_count+1.
  - Lowering tlast_interval below group_count therefore terminates the group on the next push.
- AXIS output:
  - M_AXIS_tvalid = FIFO not empty.
  - tdata/tlast present the head entry; both are 0 when tvalid=0.
  - Pop on tvalid & tready.
  - Latency: a push in cycle n is visible at the output in cycle n+1 (when the FIFO was empty).
  - Output data are stable while tvalid=1 and tready=0.
  - Packets are delivered in order, with no duplication.
- Simultaneous push and pop:
  - When full: accepted, occupancy unchanged.
  - When empty: there is no pop (tvalid=0); the push proceeds.
- Reset mid-operation discards all buffered packets next cycle. No partial packet survives.

Decomposition:
- Shared package (cms_pkg):
  - XLEN, RISC_V_INSTRUCTION_WIDTH, NO_OF_PERFORMANCE_EVENTS, PERFORMANCE_EVENT_MOD_COUNTER_WIDTH, AXI_DATA_WIDTH, WFI_INSTRUCTION.
  - A function computing packet width.
- One natural sub-module, cms_sync_fifo: parameterised width/depth, synchronous, full/empty flags.
- Counters and edge detector stay inline.

Test Plan:
- ctrl_we held high 5 cycles (CTRL_WE_POSEDGE=1) -> ctrl_we_pulse high exactly 1 cycle, the first; with CTRL_WE_POSEDGE=0 -> high all 5.
- Event bit 3 high 4 cycles, then write_enable -> captured counter[3]=4, others 0; next cycle all counters 0.
- Event bit 0 high 200 cycles (COUNTER_WIDTH=7), then write -> counter[0] field=127.
- tlast_interval=3, tready=1, 7 writes -> tlast on packets 3 and 6 only; tlast_req on packet 2 -> tlast on packets 2 and 5.
- tready=0, 20 writes with FIFO_DEPTH=16 -> tvalid=1, 16 packets buffered, dropped_count=4. Then tready=1 -> exactly 16 packets drained in order, then tvalid=0.
- FIFO full, write_enable and tready both 1 -> push accepted, dropped_count unchanged. rst asserted with 5 packets buffered -> tvalid=0 next cycle.
